// File: rtl/sync_filter_edge_pkg.sv
// Shared definitions for the sync_filter_edge synchroniser family.
//   MIN_STAGES  : shortest legal synchronisation chain
//   edge_t      : classification of a SYNC update (none / rise / fall)
//   clog2_c     : constant ceil(log2) helper
//   cnt_width   : filter counter width for a given FILTER_LEN
package sync_filter_edge_pkg;

    localparam int MIN_STAGES = 2;

    typedef enum logic [1:0] {
        EDGE_NONE,
        EDGE_RISE,
        EDGE_FALL
    } edge_t;

    function automatic int clog2_c(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

    // Counter must hold 0..FILTER_LEN; never narrower than one bit.
    function automatic int cnt_width(input int filter_len);
        int w;
        w = clog2_c(filter_len + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sync_filter_edge_if.sv
// Channel bundle of the synchroniser.
//   ASYNC : asynchronous level inputs, one per channel
//   SYNC  : synchronised, filtered levels
//   RISE  : one-cycle pulse on a SYNC 0->1 update
//   FALL  : one-cycle pulse on a SYNC 1->0 update
//   CHG   : RISE | FALL
// master drives ASYNC and observes the results; slave is the synchroniser.
interface sync_filter_edge_if #(
    parameter int BUS_WIDTH = 4
);

    logic [BUS_WIDTH-1:0] ASYNC;
    logic [BUS_WIDTH-1:0] SYNC;
    logic [BUS_WIDTH-1:0] RISE;
    logic [BUS_WIDTH-1:0] FALL;
    logic [BUS_WIDTH-1:0] CHG;

    modport master (
        output ASYNC,
        input  SYNC,
        input  RISE,
        input  FALL,
        input  CHG
    );

    modport slave (
        input  ASYNC,
        output SYNC,
        output RISE,
        output FALL,
        output CHG
    );

endinterface

// File: rtl/sync_filter_bit.sv
// One synchroniser channel: flop chain, stability filter, SYNC flop and
// registered edge pulses.
//   clk     : destination clock
//   rst     : asynchronous active-high reset
//   async_i : asynchronous level input
//   sync_o  : filtered synchronised level
//   rise_o  : pulse for the cycle after a 0->1 update of sync_o
//   fall_o  : pulse for the cycle after a 1->0 update of sync_o
//   chg_o   : rise_o | fall_o, registered alongside them
module sync_filter_bit
    import sync_filter_edge_pkg::*;
#(
    parameter int   NUM_STAGES = 2,
    parameter int   FILTER_LEN = 0,
    parameter logic RST_VAL    = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o,
    output logic chg_o
);

    localparam int             CNT_W   = cnt_width(FILTER_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_LEN);

    logic [NUM_STAGES-1:0] stage_q, stage_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  sync_q, sync_d;
    logic                  rise_q, rise_d;
    logic                  fall_q, fall_d;
    logic                  chg_q, chg_d;
    logic                  chain_out;

    assign chain_out = stage_q[NUM_STAGES-1];

    always_comb begin
        // Pure shift: nothing may sit between synchroniser flops.
        stage_d = {stage_q[NUM_STAGES-2:0], async_i};
        cnt_d   = cnt_q;
        sync_d  = sync_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        chg_d   = 1'b0;
        if (chain_out == sync_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            // Chain output has disagreed for FILTER_LEN+1 edges: accept it.
            sync_d = chain_out;
            cnt_d  = '0;
            rise_d = chain_out;
            fall_d = ~chain_out;
            chg_d  = 1'b1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q <= {NUM_STAGES{RST_VAL}};
            cnt_q   <= '0;
            sync_q  <= RST_VAL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            chg_q   <= 1'b0;
        end else begin
            stage_q <= stage_d;
            cnt_q   <= cnt_d;
            sync_q  <= sync_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            chg_q   <= chg_d;
        end
    end

    assign sync_o = sync_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;
    assign chg_o  = chg_q;

endmodule

// File: rtl/sync_filter_edge.sv
// Multi-channel synchroniser for slow asynchronous level signals with
// glitch filtering and registered rise/fall/change pulses.
//   CLK : destination-domain clock
//   RST : asynchronous active-high reset
//   bus : slave side of sync_filter_edge_if (ASYNC in; SYNC/RISE/FALL/CHG out)
// Each channel is independent; RST_VAL gives the per-channel reset level.
// Not suitable for multi-bit values such as counters.
module sync_filter_edge
    import sync_filter_edge_pkg::*;
#(
    parameter int                   BUS_WIDTH  = 4,
    parameter int                   NUM_STAGES = 2,
    parameter int                   FILTER_LEN = 0,
    parameter logic [BUS_WIDTH-1:0] RST_VAL    = '0
) (
    input  logic               CLK,
    input  logic               RST,
    sync_filter_edge_if.slave  bus
);

    if (NUM_STAGES < MIN_STAGES) begin : g_bad_stages
        $error("sync_filter_edge: NUM_STAGES must be at least 2");
    end
    if (BUS_WIDTH < 1) begin : g_bad_width
        $error("sync_filter_edge: BUS_WIDTH must be at least 1");
    end

    logic [BUS_WIDTH-1:0] sync_w;
    logic [BUS_WIDTH-1:0] rise_w;
    logic [BUS_WIDTH-1:0] fall_w;
    logic [BUS_WIDTH-1:0] chg_w;

    for (genvar i = 0; i < BUS_WIDTH; i++) begin : g_ch
        sync_filter_bit #(
            .NUM_STAGES (NUM_STAGES),
            .FILTER_LEN (FILTER_LEN),
            .RST_VAL    (RST_VAL[i])
        ) u_bit (
            .clk     (CLK),
            .rst     (RST),
            .async_i (bus.ASYNC[i]),
            .sync_o  (sync_w[i]),
            .rise_o  (rise_w[i]),
            .fall_o  (fall_w[i]),
            .chg_o   (chg_w[i])
        );
    end

    assign bus.SYNC = sync_w;
    assign bus.RISE = rise_w;
    assign bus.FALL = fall_w;
    assign bus.CHG  = chg_w;

endmodule

// File: tb/tb_sync_filter_edge.sv
module tb_sync_filter_edge;
    import sync_filter_edge_pkg::*;

    localparam int         NS_A = 2;
    localparam int         FL_A = 3;
    localparam logic [3:0] RV_A = 4'b0000;
    localparam int         NS_B = 3;
    localparam int         FL_B = 0;
    localparam logic [3:0] RV_B = 4'b0101;

    logic CLK = 1'b0;
    logic RST;

    always #5 CLK = ~CLK;

    sync_filter_edge_if #(.BUS_WIDTH(4)) if_a ();
    sync_filter_edge_if #(.BUS_WIDTH(4)) if_b ();

    sync_filter_edge #(
        .BUS_WIDTH(4), .NUM_STAGES(NS_A), .FILTER_LEN(FL_A), .RST_VAL(RV_A)
    ) u_a (
        .CLK (CLK),
        .RST (RST),
        .bus (if_a)
    );

    sync_filter_edge #(
        .BUS_WIDTH(4), .NUM_STAGES(NS_B), .FILTER_LEN(FL_B), .RST_VAL(RV_B)
    ) u_b (
        .CLK (CLK),
        .RST (RST),
        .bus (if_b)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: SYNC flips at an edge when the chain output seen at
    // that edge and the FILTER_LEN edges before it all disagree with SYNC.
    // The chain output seen at edge t is the input sampled at edge t-NUM_STAGES
    // (or the reset value if that edge predates the last reset).
    logic [3:0] hist [2][8192];
    int         ecount [2];
    logic [3:0] msync [2];
    edge_t      medge [2][4];

    task automatic model_reset(input int d);
        ecount[d] = 0;
        msync[d]  = (d == 0) ? RV_A : RV_B;
        for (int c = 0; c < 4; c++) medge[d][c] = EDGE_NONE;
    endtask

    task automatic model_edge(input int d, input logic [3:0] a);
        int ns, fl, t;
        logic [3:0] rv, h;
        logic all_diff, s;
        ns = (d == 0) ? NS_A : NS_B;
        fl = (d == 0) ? FL_A : FL_B;
        rv = (d == 0) ? RV_A : RV_B;
        ecount[d]++;
        hist[d][ecount[d]] = a;
        for (int c = 0; c < 4; c++) begin
            all_diff = 1'b1;
            for (int j = 0; j <= fl; j++) begin
                t = ecount[d] - j - ns;
                if (t >= 1) begin
                    h = hist[d][t];
                    s = h[c];
                end else begin
                    s = rv[c];
                end
                if (s == msync[d][c]) all_diff = 1'b0;
            end
            medge[d][c] = EDGE_NONE;
            if (all_diff) begin
                medge[d][c] = msync[d][c] ? EDGE_FALL : EDGE_RISE;
                msync[d][c] = ~msync[d][c];
            end
        end
    endtask

    function automatic logic [3:0] edge_vec(input int d, input edge_t kind);
        logic [3:0] v;
        v = '0;
        for (int c = 0; c < 4; c++) v[c] = (medge[d][c] == kind);
        return v;
    endfunction

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        logic [3:0] r, f;
        r = edge_vec(0, EDGE_RISE);
        f = edge_vec(0, EDGE_FALL);
        chk("mdl_a.SYNC", if_a.SYNC, msync[0]);
        chk("mdl_a.RISE", if_a.RISE, r);
        chk("mdl_a.FALL", if_a.FALL, f);
        chk("mdl_a.CHG",  if_a.CHG,  r | f);
        r = edge_vec(1, EDGE_RISE);
        f = edge_vec(1, EDGE_FALL);
        chk("mdl_b.SYNC", if_b.SYNC, msync[1]);
        chk("mdl_b.RISE", if_b.RISE, r);
        chk("mdl_b.FALL", if_b.FALL, f);
        chk("mdl_b.CHG",  if_b.CHG,  r | f);
    endtask

    // Drive both channel sets at the falling edge, take one rising edge,
    // then compare both DUTs against the model shortly after it.
    task automatic step(input logic [3:0] a, input logic [3:0] b);
        @(negedge CLK);
        if_a.ASYNC = a;
        if_b.ASYNC = b;
        @(posedge CLK);
        model_edge(0, a);
        model_edge(1, b);
        #1;
        check_model();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".a.SYNC"}, if_a.SYNC, RV_A);
        chk({tag, ".a.RISE"}, if_a.RISE, 4'b0000);
        chk({tag, ".a.FALL"}, if_a.FALL, 4'b0000);
        chk({tag, ".a.CHG"},  if_a.CHG,  4'b0000);
        chk({tag, ".b.SYNC"}, if_b.SYNC, RV_B);
        chk({tag, ".b.CHG"},  if_b.CHG,  4'b0000);
    endtask

    typedef struct {
        logic [3:0] async_v;
        int         reps;
        logic [3:0] sync_v;
        logic [3:0] rise_v;
        logic [3:0] fall_v;
    } vec_t;

    vec_t tbl [11];

    initial begin
        logic [3:0] cur_a, cur_b, flip;
        logic [3:0] b_sync_exp, b_prev_exp, b_rise_exp, b_fall_exp;
        logic       drv [40];
        logic       v, e_now, e_prev;

        // FILTER_LEN=3, NUM_STAGES=2 on u_a: latency, short glitch, 4-cycle pulse.
        tbl[0]  = '{4'b0001, 5, 4'b0000, 4'b0000, 4'b0000};
        tbl[1]  = '{4'b0001, 1, 4'b0001, 4'b0001, 4'b0000};
        tbl[2]  = '{4'b0001, 2, 4'b0001, 4'b0000, 4'b0000};
        tbl[3]  = '{4'b0011, 2, 4'b0001, 4'b0000, 4'b0000};
        tbl[4]  = '{4'b0001, 6, 4'b0001, 4'b0000, 4'b0000};
        tbl[5]  = '{4'b0011, 4, 4'b0001, 4'b0000, 4'b0000};
        tbl[6]  = '{4'b0001, 1, 4'b0001, 4'b0000, 4'b0000};
        tbl[7]  = '{4'b0001, 1, 4'b0011, 4'b0010, 4'b0000};
        tbl[8]  = '{4'b0001, 3, 4'b0011, 4'b0000, 4'b0000};
        tbl[9]  = '{4'b0001, 1, 4'b0001, 4'b0000, 4'b0010};
        tbl[10] = '{4'b0001, 2, 4'b0001, 4'b0000, 4'b0000};

        RST = 1'b1;
        if_a.ASYNC = 4'b0000;
        if_b.ASYNC = RV_B;
        model_reset(0);
        model_reset(1);
        #1;
        check_reset_outputs("rst0");
        @(posedge CLK);
        #2;
        RST = 1'b0;

        // Table phase; u_b holds ASYNC equal to its reset value and must stay silent.
        for (int r = 0; r < 11; r++) begin
            for (int k = 0; k < tbl[r].reps; k++) begin
                step(tbl[r].async_v, RV_B);
                chk($sformatf("tbl%0d.SYNC", r), if_a.SYNC, tbl[r].sync_v);
                chk($sformatf("tbl%0d.RISE", r), if_a.RISE, tbl[r].rise_v);
                chk($sformatf("tbl%0d.FALL", r), if_a.FALL, tbl[r].fall_v);
                chk($sformatf("tbl%0d.CHG", r),  if_a.CHG,  tbl[r].rise_v | tbl[r].fall_v);
                chk("rstval.b.SYNC", if_b.SYNC, RV_B);
                chk("rstval.b.CHG",  if_b.CHG,  4'b0000);
            end
        end

        // u_b (FILTER_LEN=0, NUM_STAGES=3): ASYNC[2] toggles every 5 cycles,
        // SYNC[2] must repeat the input driven three steps earlier.
        b_prev_exp = RV_B;
        for (int k = 0; k < 40; k++) begin
            v = ((k / 5) % 2 == 0) ? 1'b0 : 1'b1;
            drv[k] = v;
            step(4'b0001, {1'b0, v, 1'b0, 1'b1});
            e_now  = (k >= 3) ? drv[k-3] : 1'b1;
            e_prev = b_prev_exp[2];
            b_sync_exp = {1'b0, e_now, 1'b0, 1'b1};
            b_rise_exp = {1'b0, e_now & ~e_prev, 2'b00};
            b_fall_exp = {1'b0, ~e_now & e_prev, 2'b00};
            chk("tog.b.SYNC", if_b.SYNC, b_sync_exp);
            chk("tog.b.RISE", if_b.RISE, b_rise_exp);
            chk("tog.b.FALL", if_b.FALL, b_fall_exp);
            b_prev_exp = b_sync_exp;
        end

        // All four u_a channels switch together in mixed directions.
        for (int k = 0; k < 10; k++) step(4'b0101, 4'b0101);
        chk("simul.pre.SYNC", if_a.SYNC, 4'b0101);
        for (int k = 0; k < 7; k++) begin
            step(4'b1010, 4'b0101);
            if (k == 4) chk("simul.k4.SYNC", if_a.SYNC, 4'b0101);
            if (k == 5) begin
                chk("simul.SYNC", if_a.SYNC, 4'b1010);
                chk("simul.RISE", if_a.RISE, 4'b1010);
                chk("simul.FALL", if_a.FALL, 4'b0101);
                chk("simul.CHG",  if_a.CHG,  4'b1111);
            end
            if (k == 6) chk("simul.after.CHG", if_a.CHG, 4'b0000);
        end

        // Reset while u_a counts (cnt=2 after two disagreeing edges).
        for (int k = 0; k < 4; k++) step(4'b0101, 4'b0101);
        chk("midcnt.pre.SYNC", if_a.SYNC, 4'b1010);
        #2;
        RST = 1'b1;
        #1;
        check_reset_outputs("midcnt");
        model_reset(0);
        model_reset(1);
        @(posedge CLK);
        #2;
        RST = 1'b0;

        // Full latency again from edge 1, then reset while RISE is high.
        for (int k = 0; k < 6; k++) begin
            step(4'b0001, 4'b0101);
            if (k == 4) chk("relat.k4.SYNC", if_a.SYNC, 4'b0000);
        end
        chk("relat.SYNC", if_a.SYNC, 4'b0001);
        chk("relat.RISE", if_a.RISE, 4'b0001);
        #2;
        RST = 1'b1;
        #1;
        check_reset_outputs("rstpulse");
        model_reset(0);
        model_reset(1);
        @(posedge CLK);
        #2;
        RST = 1'b0;

        // Randomised level traffic on both DUTs, checked against the model.
        cur_a = 4'b0000;
        cur_b = RV_B;
        for (int k = 0; k < 500; k++) begin
            flip = '0;
            for (int c = 0; c < 4; c++) flip[c] = ($urandom_range(0, 3) == 0);
            cur_a = cur_a ^ flip;
            for (int c = 0; c < 4; c++) flip[c] = ($urandom_range(0, 2) == 0);
            cur_b = cur_b ^ flip;
            step(cur_a, cur_b);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
